muldiv_wb: RTL

Iterative 8-bit unsigned multiply/divide execution stage sitting directly downstream of the register file read ports and upstream of its write port. On `start` it captures the two read-port operands and a destination register pointer. It runs an 8-step shift-add multiply or restoring divide. It then drives the register file write port for two consecutive cycles: low result byte to `dst`, high result byte to `dst+1`.

---
 rtl/muldiv_wb_if.sv | 27 ++
 rtl/muldiv_wb.sv | 127 ++++++++++++
 2 files changed

// File: rtl/muldiv_wb_if.sv
// Operand/request and register-file write-port bundle for the muldiv_wb execution stage.
// master drives requests and observes the write port; slave is the execution stage.
interface muldiv_wb_if #(
  parameter int unsigned pw = 4
);
  logic          start;
  logic          op;
  logic [7:0]    datA;
  logic [7:0]    datB;
  logic [pw-1:0] dst;
  logic          busy;
  logic          done;
  logic          wr_en;
  logic [pw-1:0] wr_addr;
  logic [7:0]    wr_dat;
  logic          div0;

  modport master (
    output start, op, datA, datB, dst,
    input  busy, done, wr_en, wr_addr, wr_dat, div0
  );

  modport slave (
    input  start, op, datA, datB, dst,
    output busy, done, wr_en, wr_addr, wr_dat, div0
  );
endinterface

// File: rtl/muldiv_wb.sv
// Iterative 8-bit unsigned multiply (shift-add) / divide (restoring) stage that writes its
// 16-bit result to the register file as two bytes: lo to dst, hi to dst+1.
module muldiv_wb #(
  parameter int unsigned pw = 4
) (
  input logic        clk,
  input logic        rst_n,
  muldiv_wb_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StCalc, StWbLo, StWbHi} state_e;

  state_e        state_q, state_d;
  logic [2:0]    cnt_q, cnt_d;
  logic          op_q, op_d;
  logic [pw-1:0] dst_q, dst_d;
  logic [7:0]    opnd_q, opnd_d;
  // MULU: {hi, lo} = {partial product, remaining multiplier}; DIVU: {remainder, quotient}.
  logic [15:0]   work_q, work_d;
  logic          div0_q, div0_d;

  logic [8:0]    mul_sum;
  logic [15:0]   mul_next;
  logic [8:0]    div_shift;
  logic [8:0]    div_diff;
  logic          div_ge;
  logic [15:0]   div_next;

  always_comb begin
    mul_sum  = {1'b0, work_q[15:8]} + (work_q[0] ? {1'b0, opnd_q} : 9'd0);
    mul_next = {mul_sum, work_q[7:1]};
    // Partial remainder never exceeds 2*divisor-1, so bit 8 of the difference is the borrow.
    div_shift = {work_q[15:8], work_q[7]};
    div_diff  = div_shift - {1'b0, opnd_q};
    div_ge    = ~div_diff[8];
    div_next  = {(div_ge ? div_diff[7:0] : div_shift[7:0]), work_q[6:0], div_ge};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    dst_d   = dst_q;
    opnd_d  = opnd_q;
    work_d  = work_q;
    div0_d  = div0_q;
    case (state_q)
      StIdle: begin
        if (bus.start) begin
          state_d = StCalc;
          cnt_d   = 3'd0;
          op_d    = bus.op;
          dst_d   = bus.dst;
          div0_d  = 1'b0;
          opnd_d  = bus.op ? bus.datB : bus.datA;
          work_d  = {8'h00, (bus.op ? bus.datA : bus.datB)};
        end
      end
      StCalc: begin
        work_d = op_q ? div_next : mul_next;
        cnt_d  = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          state_d = StWbLo;
        end
      end
      StWbLo: begin
        state_d = StWbHi;
        if (op_q && (opnd_q == 8'h00)) begin
          div0_d = 1'b1;
        end
      end
      StWbHi: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= 3'd0;
      op_q    <= 1'b0;
      dst_q   <= '0;
      opnd_q  <= 8'h00;
      work_q  <= 16'h0000;
      div0_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      dst_q   <= dst_d;
      opnd_q  <= opnd_d;
      work_q  <= work_d;
      div0_q  <= div0_d;
    end
  end

  // Outputs decode registered state only.
  always_comb begin
    bus.busy    = (state_q != StIdle);
    bus.done    = 1'b0;
    bus.wr_en   = 1'b0;
    bus.wr_addr = '0;
    bus.wr_dat  = 8'h00;
    bus.div0    = div0_q;
    case (state_q)
      StWbLo: begin
        bus.wr_en   = 1'b1;
        bus.wr_addr = dst_q;
        bus.wr_dat  = work_q[7:0];
      end
      StWbHi: begin
        bus.wr_en   = 1'b1;
        bus.done    = 1'b1;
        bus.wr_addr = dst_q + {{(pw-1){1'b0}}, 1'b1};
        bus.wr_dat  = work_q[15:8];
      end
      default: begin
        bus.done = 1'b0;
      end
    endcase
  end

endmodule
